// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame constants and
// the parity helper. Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // Even-parity bit of a data word; zero-extension does not change the XOR.
    function automatic logic uart_even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line plus falling-edge
// detector. All flops reset to 1 (idle line level) so reset never looks like
// a start edge.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rstb_i,
    input  logic rxd,
    output logic rxd_s,
    output logic fall_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain and one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rxd_s      = sync2_q;
    assign fall_pulse = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_receiver_fsm.sv
// UART receiver: oversampled start/data/stop sampling with one-cycle result
// strobes. Optional even parity bit is enabled with the UART_RX_PARITY_EN
// macro; without it the frame format is 8N1 and parity_err is tied low.
module uart_receiver_fsm
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = UART_DATA_W,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE  // even, >= 4
) (
    input  logic              clk_i,
    input  logic              rstb_i,
    input  logic              rxd,
    input  logic              baud_tick,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_W + 1);

    localparam logic [TW-1:0] TickHalf = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BitLast  = BW'(DATA_W - 1);

    logic rxd_s;
    logic fall_pulse;

    uart_rx_sync u_sync (
        .clk_i      (clk_i),
        .rstb_i     (rstb_i),
        .rxd        (rxd),
        .rxd_s      (rxd_s),
        .fall_pulse (fall_pulse)
    );

    uart_state_e       state_q;
    logic [TW-1:0]     tick_cnt_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    // Cleared by a framing error; a break must return high before re-arming.
    logic              armed_q;
`ifdef UART_RX_PARITY_EN
    logic              parity_err_q;
    logic              par_mis_q;
`endif

    // Receive FSM with registered result strobes.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            armed_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_mis_q    <= 1'b0;
`endif
        end else begin
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (rxd_s) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (fall_pulse && armed_q) begin
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= StStart;
                    end
                end

                StStart: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == TickHalf) begin
                            tick_cnt_q <= '0;
                            // A high line at the start-bit centre was a glitch.
                            state_q    <= rxd_s ? StIdle : StData;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                StData: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == TickLast) begin
                            tick_cnt_q <= '0;
                            shift_q    <= {rxd_s, shift_q[DATA_W-1:1]};
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= StParity;
`else
                                state_q <= StStop;
`endif
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == TickLast) begin
                            tick_cnt_q <= '0;
                            par_mis_q  <= uart_even_parity(32'(shift_q)) ^ rxd_s;
                            state_q    <= StStop;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
`endif

                StStop: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == TickLast) begin
                            tick_cnt_q <= '0;
                            state_q    <= StIdle;
                            if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                                if (par_mis_q) begin
                                    parity_err_q <= 1'b1;
                                end else begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end
`else
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
`endif
                            end else begin
                                frame_err_q <= 1'b1;
                                armed_q     <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Self-checking bench for uart_receiver_fsm: table of frames plus hand-written
// glitch, break, back-to-back, mid-frame reset and (when enabled) parity cases.
module tb_uart_receiver_fsm;

    localparam int CLK_DIV  = 4;               // clk cycles per baud_tick
    localparam int BIT_CLKS = 16 * CLK_DIV;    // OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    localparam bit UsePar = 1'b1;
`else
    localparam bit UsePar = 1'b0;
`endif

    localparam int KValid  = 0;
    localparam int KFrame  = 1;
    localparam int KParity = 2;

    logic       clk_i     = 1'b0;
    logic       rstb_i    = 1'b0;
    logic       rxd       = 1'b1;
    logic       baud_tick = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    uart_receiver_fsm dut (
        .clk_i      (clk_i),
        .rstb_i     (rstb_i),
        .rxd        (rxd),
        .baud_tick  (baud_tick),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         kind;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    int   last_pulse_cyc = 0;
    int   stop_start_cyc = 0;
    bit   prev_pulse     = 1'b0;
    int   mon_kind;
    exp_t mon_e;
    int   tick_div = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        rxd = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clks(BIT_CLKS);
        end
        if (UsePar) begin
            rxd = (^d) ^ par_flip;
            wait_clks(BIT_CLKS);
        end
        stop_start_cyc = cyc;
        rxd = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    // Baud tick: one clk-wide pulse every CLK_DIV cycles.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            baud_tick = (tick_div == CLK_DIV - 1);
            tick_div  = (tick_div + 1) % CLK_DIV;
        end
    end

    // Scoreboard: every result strobe pops and checks the oldest expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rstb_i && (rx_valid || frame_err || parity_err)) begin
                mon_kind = rx_valid ? KValid : (frame_err ? KFrame : KParity);
                check("one_strobe", 32'($countones({rx_valid, frame_err, parity_err})), 1);
                check("strobe_width", 32'(prev_pulse), 0);
                last_pulse_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got kind %0d data 0x%0h, none expected",
                             mon_kind, rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
                    check("strobe_data", 32'(rx_data), 32'(mon_e.data));
                end
            end
            prev_pulse = rstb_i && (rx_valid || frame_err || parity_err);
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, KValid, 8'hA5};
        vecs[1] = '{8'h01, 1'b1, KValid, 8'h01};
        vecs[2] = '{8'h80, 1'b1, KValid, 8'h80};
        vecs[3] = '{8'h3C, 1'b0, KFrame, 8'h80};
        vecs[4] = '{8'h6E, 1'b1, KValid, 8'h6E};
        vecs[5] = '{8'hFF, 1'b0, KFrame, 8'h6E};

        // Reset state
        wait_clks(3);
        check("rst_data", 32'(rx_data), 0);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_perr", 32'(parity_err), 0);
        check("rst_busy", 32'(rx_busy), 0);
        rstb_i = 1'b1;
        wait_clks(5);

        // Table of frames
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{vecs[i].kind, vecs[i].exp_data});
            send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0);
            rxd = 1'b1;
            wait_clks(2 * BIT_CLKS);
            check("vec_busy", 32'(rx_busy), 0);
            check("vec_data", 32'(rx_data), 32'(vecs[i].exp_data));
            check("vec_drain", 32'(exp_q.size()), 0);
            if (vecs[i].kind == KValid) begin
                check("vec_timing", 32'((last_pulse_cyc - stop_start_cyc >= 28) &&
                                        (last_pulse_cyc - stop_start_cyc <= 44)), 1);
            end
        end

        // Short low glitch: START sample sees high, back to IDLE silently
        rxd = 1'b0;
        wait_clks(4 * CLK_DIV);
        check("glitch_busy_hi", 32'(rx_busy), 1);
        rxd = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check("glitch_busy_lo", 32'(rx_busy), 0);
        check("glitch_data", 32'(rx_data), 32'h6E);
        check("glitch_drain", 32'(exp_q.size()), 0);

        // Bad stop bit followed by a held-low break
        exp_q.push_back('{KFrame, 8'h6E});
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(3 * BIT_CLKS);
        check("break_busy", 32'(rx_busy), 0);
        check("break_drain", 32'(exp_q.size()), 0);
        check("break_data", 32'(rx_data), 32'h6E);
        rxd = 1'b1;
        wait_clks(BIT_CLKS);
        check("break_release_busy", 32'(rx_busy), 0);

        // Back-to-back frames, no idle gap
        exp_q.push_back('{KValid, 8'h00});
        exp_q.push_back('{KValid, 8'hFF});
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_clks(2 * BIT_CLKS);
        check("b2b_drain", 32'(exp_q.size()), 0);
        check("b2b_data", 32'(rx_data), 32'hFF);
        check("b2b_busy", 32'(rx_busy), 0);

        // Reset during data bit 3 of 0xF8 (bits 3..7 high, so no edge afterwards)
        rxd = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b0;
            wait_clks(BIT_CLKS);
        end
        rxd = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rstb_i = 1'b0;
        #2;
        check("mid_rst_data", 32'(rx_data), 0);
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_ferr", 32'(frame_err), 0);
        check("mid_rst_perr", 32'(parity_err), 0);
        check("mid_rst_busy", 32'(rx_busy), 0);
        wait_clks(4);
        rstb_i = 1'b1;
        wait_clks(BIT_CLKS / 2 - 4 + 5 * BIT_CLKS + (UsePar ? BIT_CLKS : 0) + 2 * BIT_CLKS);
        check("post_rst_busy", 32'(rx_busy), 0);
        check("post_rst_data", 32'(rx_data), 0);
        check("post_rst_drain", 32'(exp_q.size()), 0);
        exp_q.push_back('{KValid, 8'h5A});
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clks(2 * BIT_CLKS);
        check("post_rst_frame", 32'(rx_data), 32'h5A);
        check("post_rst_frame_drain", 32'(exp_q.size()), 0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit, then correct parity bit
        exp_q.push_back('{KParity, 8'h5A});
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(2 * BIT_CLKS);
        check("par_bad_data", 32'(rx_data), 32'h5A);
        check("par_bad_drain", 32'(exp_q.size()), 0);
        exp_q.push_back('{KValid, 8'h07});
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(2 * BIT_CLKS);
        check("par_ok_data", 32'(rx_data), 32'h07);
        check("par_ok_drain", 32'(exp_q.size()), 0);
`endif

        check("final_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
